// File: rtl/byte_unstriping_if.sv
// Lane-input / reassembled-output bundle for byte_unstriping.
// master drives the two lanes and observes the merged stream; slave is the design side.
interface byte_unstriping_if;
    logic [31:0] lane0;
    logic [31:0] lane1;
    logic        valid_0;
    logic        valid_1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        err;

    modport master (
        output lane0, lane1, valid_0, valid_1,
        input  data_out, valid_out, err
    );

    modport slave (
        input  lane0, lane1, valid_0, valid_1,
        output data_out, valid_out, err
    );
endinterface

// File: rtl/byte_unstriping.sv
// Two-lane word unstriper: per-lane FIFOs drained in strict lane0/lane1 alternation.
// Optional sticky overflow flag enabled by macro UNSTRIPE_OVERFLOW_ERR_EN.
module byte_unstriping #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_2f,
    input  logic                reset_L,
    byte_unstriping_if.slave    bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]                mem_q [2][FIFO_DEPTH];
    logic [1:0][PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0][PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [1:0][CNT_W-1:0]      count_q, count_d;
    logic                       rd_sel_q, rd_sel_d;
    logic [31:0]                data_out_q, data_out_d;
    logic                       valid_out_q, valid_out_d;

    logic [1:0]                 valid_in_s;
    logic [1:0][31:0]           lane_in_s;
    logic [1:0]                 push_s, pop_s, full_s, empty_s;

    assign valid_in_s = {bus.valid_1, bus.valid_0};
    assign lane_in_s  = {bus.lane1, bus.lane0};

    // Push/pop decisions, pointer/count updates and output selection.
    always_comb begin
        push_s      = 2'b00;
        pop_s       = 2'b00;
        full_s      = 2'b00;
        empty_s     = 2'b00;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_sel_d    = rd_sel_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        for (int k = 0; k < 2; k++) begin
            full_s[k]  = (count_q[k] == FULL_CNT);
            empty_s[k] = (count_q[k] == {CNT_W{1'b0}});
            pop_s[k]   = (rd_sel_q == 1'(k)) && !empty_s[k];
            // A pop on a full FIFO frees the slot for this edge's push.
            push_s[k]  = valid_in_s[k] && (!full_s[k] || pop_s[k]);
            if (push_s[k]) begin
                wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
            end else begin
                wr_ptr_d[k] = wr_ptr_q[k];
            end
            if (pop_s[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
            end else begin
                rd_ptr_d[k] = rd_ptr_q[k];
            end
            case ({push_s[k], pop_s[k]})
                2'b10:   count_d[k] = count_q[k] + CNT_W'(1);
                2'b01:   count_d[k] = count_q[k] - CNT_W'(1);
                default: count_d[k] = count_q[k];
            endcase
        end
        // rd_sel holds on an empty selected lane to keep strict alternation.
        if (|pop_s) begin
            data_out_d  = mem_q[rd_sel_q][rd_ptr_q[rd_sel_q]];
            valid_out_d = 1'b1;
            rd_sel_d    = ~rd_sel_q;
        end else begin
            data_out_d  = data_out_q;
            valid_out_d = 1'b0;
            rd_sel_d    = rd_sel_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_sel_q    <= 1'b0;
            data_out_q  <= 32'h0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_sel_q    <= rd_sel_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Lane FIFO storage.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[k][i] <= 32'h0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push_s[k]) begin
                    mem_q[k][wr_ptr_q[k]] <= lane_in_s[k];
                end
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;

`ifdef UNSTRIPE_OVERFLOW_ERR_EN
    logic       err_q;
    logic [1:0] drop_s;

    // A push is dropped only when the FIFO is full and not popped this edge.
    always_comb begin
        drop_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            drop_s[k] = valid_in_s[k] && full_s[k] && !pop_s[k];
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|drop_s);
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed self-checking bench for byte_unstriping; expectations are hand-derived per edge.
module tb_byte_unstriping;

    logic clk_2f;
    logic reset_L;
    int   checks;
    int   failures;

    byte_unstriping_if bus ();

    byte_unstriping #(.FIFO_DEPTH(4)) dut (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

`ifdef UNSTRIPE_OVERFLOW_ERR_EN
    localparam logic ERR_ON_DROP = 1'b1;
`else
    localparam logic ERR_ON_DROP = 1'b0;
`endif

    // Apply lane inputs, then advance one rising edge and settle.
    task automatic drive_edge(input logic v0, input logic [31:0] d0,
                              input logic v1, input logic [31:0] d1);
        bus.valid_0 = v0;
        bus.lane0   = d0;
        bus.valid_1 = v1;
        bus.lane1   = d1;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic apply_reset();
        bus.valid_0 = 1'b0;
        bus.valid_1 = 1'b0;
        bus.lane0   = 32'h0;
        bus.lane1   = 32'h0;
        reset_L     = 1'b0;
        @(posedge clk_2f);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L     = 1'b0;
        bus.valid_0 = 1'b1;
        bus.valid_1 = 1'b1;
        bus.lane0   = 32'h12345678;
        bus.lane1   = 32'h9ABCDEF0;
        #2;
        checks++;
        if (bus.data_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: data_out=%h valid_out=%b err=%b required 00000000/0/0",
                     bus.data_out, bus.valid_out, bus.err);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_2f);
            #1;
            checks++;
            if (bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
                failures++;
                $display("FAIL reset_held edge %0d: data_out=%h valid_out=%b required 00000000/0",
                         i, bus.data_out, bus.valid_out);
            end
        end
        bus.valid_0 = 1'b0;
        bus.valid_1 = 1'b0;
        reset_L     = 1'b1;
        drive_edge(1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: valid_out=%b required 0 (no word held through reset)",
                     bus.valid_out);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] exp_d [3] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic        exp_v [3] = '{1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_edge(i == 0, 32'hFFFFFFFF, 1'b0, 32'h0);
            checks++;
            if (bus.valid_out !== exp_v[i] || bus.data_out !== exp_d[i]) begin
                failures++;
                $display("FAIL single_word edge %0d: data_out=%h valid_out=%b required %h/%b",
                         i, bus.data_out, bus.valid_out, exp_d[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_interleave();
        logic [31:0] in0 [3] = '{32'hFFFFFFFF, 32'hDDDDDDDD, 32'hBBBBBBBB};
        logic [31:0] in1 [3] = '{32'hEEEEEEEE, 32'hCCCCCCCC, 32'hAAAAAAAA};
        logic [31:0] exp_d [8] = '{32'h0, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD,
                                   32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'hAAAAAAAA};
        logic        exp_v [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) drive_edge(1'b1, in0[i], 1'b1, in1[i]);
            else       drive_edge(1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if (bus.valid_out !== exp_v[i] || bus.data_out !== exp_d[i]) begin
                failures++;
                $display("FAIL interleave edge %0d: data_out=%h valid_out=%b required %h/%b",
                         i, bus.data_out, bus.valid_out, exp_d[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_lane_order();
        logic [31:0] exp_d [6] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h2, 32'h2};
        logic        exp_v [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_edge(i == 2, 32'h1, i == 0, 32'h2);
            checks++;
            if (bus.valid_out !== exp_v[i] || bus.data_out !== exp_d[i]) begin
                failures++;
                $display("FAIL lane_order edge %0d: data_out=%h valid_out=%b required %h/%b",
                         i, bus.data_out, bus.valid_out, exp_d[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_d [11] = '{32'd10, 32'd1, 32'd11, 32'd2, 32'd12, 32'd3,
                                    32'd13, 32'd4, 32'd4, 32'd4, 32'd4};
        logic        exp_v [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b0, 32'h0, 1'b1, 32'(i + 1));
            checks++;
            if (bus.valid_out !== 1'b0 || bus.err !== ((i == 4) ? ERR_ON_DROP : 1'b0)) begin
                failures++;
                $display("FAIL overflow_fill edge %0d: valid_out=%b err=%b required 0/%b",
                         i, bus.valid_out, bus.err, (i == 4) ? ERR_ON_DROP : 1'b0);
            end
        end
        drive_edge(1'b1, 32'd10, 1'b0, 32'h0);
        for (int i = 0; i < 11; i++) begin
            drive_edge(i < 3, 32'(11 + i), 1'b0, 32'h0);
            checks++;
            if (bus.valid_out !== exp_v[i] || bus.data_out !== exp_d[i] || bus.err !== ERR_ON_DROP) begin
                failures++;
                $display("FAIL overflow_drain edge %0d: data_out=%h valid_out=%b err=%b required %h/%b/%b",
                         i, bus.data_out, bus.valid_out, bus.err, exp_d[i], exp_v[i], ERR_ON_DROP);
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_d [10] = '{32'd30, 32'd21, 32'd31, 32'd22, 32'd32, 32'd23,
                                    32'd33, 32'd24, 32'd34, 32'd25};
        logic        in_v0 [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] in_d0 [10] = '{32'd31, 32'd0, 32'd32, 32'd33, 32'd34, 32'd0,
                                    32'd0, 32'd0, 32'd0, 32'd0};
        apply_reset();
        for (int i = 0; i < 4; i++) drive_edge(1'b0, 32'h0, 1'b1, 32'(21 + i));
        drive_edge(1'b1, 32'd30, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            // Second drain edge pops full lane1 while pushing word 25 into it.
            drive_edge(in_v0[i], in_d0[i], i == 1, 32'd25);
            checks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== exp_d[i] || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL full_push_pop edge %0d: data_out=%h valid_out=%b err=%b required %h/1/0",
                         i, bus.data_out, bus.valid_out, bus.err, exp_d[i]);
            end
        end
        drive_edge(1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (bus.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop_end: valid_out=%b required 0", bus.valid_out);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp_d [3] = '{32'd44, 32'd55, 32'd55};
        logic        exp_v [3] = '{1'b1, 1'b1, 1'b0};
        apply_reset();
        drive_edge(1'b1, 32'd7, 1'b0, 32'h0);
        drive_edge(1'b1, 32'd8, 1'b0, 32'h0);
        drive_edge(1'b1, 32'd9, 1'b0, 32'h0);
        drive_edge(1'b1, 32'd10, 1'b0, 32'h0);
        drive_edge(1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (bus.data_out !== 32'd7 || bus.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL midstream_pre: data_out=%h valid_out=%b required 00000007/0",
                     bus.data_out, bus.valid_out);
        end
        #2;
        reset_L = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL midstream_async: data_out=%h valid_out=%b err=%b required 00000000/0/0",
                     bus.data_out, bus.valid_out, bus.err);
        end
        @(posedge clk_2f);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if (bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
                failures++;
                $display("FAIL midstream_after edge %0d: data_out=%h valid_out=%b required 00000000/0",
                         i, bus.data_out, bus.valid_out);
            end
        end
        drive_edge(1'b1, 32'd44, 1'b1, 32'd55);
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if (bus.valid_out !== exp_v[i] || bus.data_out !== exp_d[i]) begin
                failures++;
                $display("FAIL first_after_reset edge %0d: data_out=%h valid_out=%b required %h/%b",
                         i, bus.data_out, bus.valid_out, exp_d[i], exp_v[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_word();
        test_interleave();
        test_lane_order();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: FIFO_DEPTH, default 4, entries per lane FIFO (power of two, minimum 2).
REQ-003 clk_2f  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 lane0  input  32  lane 0 word (even-numbered words of the original stream).
REQ-006 lane1  input  32  lane 1 word (odd-numbered words of the original stream).
REQ-007 valid_0  input  1  lane0 carries a word this cycle.
REQ-008 valid_1  input  1  lane1 carries a word this cycle.
REQ-009 data_out  output  32  reassembled word, registered.
REQ-010 valid_out  output  1  data_out valid this cycle, registered.
REQ-011 err  output  1  sticky lane-overflow flag, registered.

Function
REQ-012 The block SHALL hold one FIFO_DEPTH x 32 FIFO per lane, with read and write pointers that wrap modulo FIFO_DEPTH and an occupancy count 0..FIFO_DEPTH.
REQ-013 A rising edge with valid_k=1 and lane k FIFO not full SHALL push lane k's word.
REQ-014 A push to a full FIFO SHALL be dropped; FIFO contents, pointers and count SHALL be unchanged.
REQ-015 A register rd_sel SHALL select the next lane to drain: 0 selects lane0, 1 selects lane1.
REQ-016 On each edge where FIFO[rd_sel] is non-empty, the block SHALL:
- set data_out to that FIFO's head word;
- set valid_out to 1;
- pop that FIFO;
- toggle rd_sel.
REQ-017 On each edge where FIFO[rd_sel] is empty:
- valid_out SHALL be 0;
- data_out SHALL hold its previous value;
- rd_sel SHALL hold, even if the other lane has data, so strict lane0/lane1 alternation is preserved.
REQ-018 Latency: a word pushed at edge N into an empty FIFO selected by rd_sel SHALL appear with valid_out=1 after edge N+1.
- A pushed word SHALL never bypass the FIFO in the same edge.
REQ-019 A simultaneous push and pop on the same FIFO SHALL both occur and leave the count unchanged.
- This includes a full FIFO: the pop frees the slot and the push is accepted, not dropped.
REQ-020 Both lanes SHALL accept pushes in the same edge independently.
REQ-021 Sustained throughput SHALL be one output word per clk_2f cycle, given both lanes keep their FIFOs non-empty.

Reset
REQ-022 While reset_L=0, regardless of clk_2f, the block SHALL force:
- data_out = 32'h0, valid_out = 0, err = 0;
- rd_sel = 0;
- both FIFOs empty (pointers and counts 0).
REQ-023 Reset asserted mid-operation SHALL discard all buffered words; no pre-reset word SHALL appear after release.
REQ-024 The first edge after reset_L deasserts SHALL process pushes normally. The first output word SHALL come from lane0.

Configuration
REQ-025 Macro UNSTRIPE_OVERFLOW_ERR_EN SHALL control overflow reporting.
- Defined: err SHALL go to 1 on the edge after the first dropped push on either lane (REQ-014). It SHALL stay 1 until reset.
- Undefined: err SHALL be constant 0 and no overflow-detection logic SHALL be synthesized. Drop behaviour of REQ-014 is unchanged.

Verification
REQ-026 Single word: reset, release, lane0=32'hFFFFFFFF with valid_0=1 for one cycle -> one cycle later data_out=32'hFFFFFFFF, valid_out=1; next cycle valid_out=0.
REQ-027 Full-rate interleave:
- Stimulus: lane0 FFFFFFFF, DDDDDDDD, BBBBBBBB; lane1 EEEEEEEE, CCCCCCCC, AAAAAAAA; pushed pairwise on consecutive edges.
- Required: data_out sequence FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC, BBBBBBBB, AAAAAAAA.
- Required: valid_out high for those 6 consecutive cycles.
REQ-028 Lane ordering: push lane1=32'h00000002 first, then lane0=32'h00000001 two cycles later -> no output until lane0 arrives; then 00000001 followed by 00000002 on consecutive cycles.
REQ-029 Overflow:
- Stimulus: push 5 words into lane1 (1..5) with lane0 idle.
- Required: 5th word dropped; with UNSTRIPE_OVERFLOW_ERR_EN, err=1 from the following edge on.
- Then push lane0 words 10, 11, 12, 13 -> output 10,1,11,2,12,3,13,4; word 5 never appears.
REQ-030 Reset mid-stream: assert reset_L=0 asynchronously with 3 words buffered -> data_out=0, valid_out=0 and err=0 immediately. After release with no new input, valid_out stays 0.
